// File: rtl/skinny_constants_inv.sv
// Reverse-order round-constant generator for SKINNY-128-384 decryption.
// Each cycle presents RNDS_PER_CLK constants, stepping backwards through the 6-bit LFSR.
module skinny_constants_inv #(
    parameter int          RNDS_PER_CLK = 4,
    parameter int          TOTAL_RNDS   = 40,
    parameter logic [5:0]  RC_LAST      = 6'h1A
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      next,
    output logic [6*RNDS_PER_CLK-1:0] constant,
    output logic                      valid,
    output logic                      last,
    output logic                      done,
    output logic [5:0]                grp
);

    localparam int         NUM_GRPS = TOTAL_RNDS / RNDS_PER_CLK;
    localparam logic [5:0] LAST_GRP = 6'(NUM_GRPS - 1);

    if ((TOTAL_RNDS % RNDS_PER_CLK) != 0) begin : g_illegal_rnds
        $error("skinny_constants_inv: RNDS_PER_CLK must divide TOTAL_RNDS");
    end

    // One step backwards through the round-constant LFSR.
    function automatic logic [5:0] lfsr_inv(input logic [5:0] n);
        return {n[0] ^ n[5] ^ 1'b1, n[5:1]};
    endfunction

    logic [5:0] rc_reg;
    logic [5:0] grp_reg;
    logic       valid_reg;
    logic       done_reg;

    logic [5:0] lane [RNDS_PER_CLK];
    logic       last_int;

    assign lane[0] = rc_reg;

    genvar gi;
    generate
        for (gi = 1; gi < RNDS_PER_CLK; gi++) begin : g_chain
            assign lane[gi] = lfsr_inv(lane[gi-1]);
        end
        for (gi = 0; gi < RNDS_PER_CLK; gi++) begin : g_pack
            assign constant[6*gi +: 6] = valid_reg ? lane[gi] : 6'h00;
        end
    endgenerate

    assign last_int = valid_reg && (grp_reg == LAST_GRP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_reg    <= RC_LAST;
            grp_reg   <= 6'd0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                // Restart takes priority over any simultaneous advance request.
                rc_reg    <= RC_LAST;
                grp_reg   <= 6'd0;
                valid_reg <= 1'b1;
            end else if (valid_reg && next) begin
                if (last_int) begin
                    rc_reg    <= RC_LAST;
                    grp_reg   <= 6'd0;
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b1;
                end else begin
                    rc_reg  <= lfsr_inv(lane[RNDS_PER_CLK-1]);
                    grp_reg <= grp_reg + 6'd1;
                end
            end
        end
    end

    assign valid = valid_reg;
    assign last  = last_int;
    assign done  = done_reg;
    assign grp   = grp_reg;

endmodule

// File: tb/tb_skinny_constants_inv.sv
// Bench for skinny_constants_inv: three widths (4, 1, 40 lanes) driven in parallel
// and compared against a round-indexed constant table built with the forward LFSR.
module tb_skinny_constants_inv;

    logic clk = 1'b0;
    logic rst_n, start, next;
    always #5 clk = ~clk;

    logic [23:0]  c4;  logic v4, l4, d4;  logic [5:0] g4;
    logic [5:0]   c1;  logic v1, l1, d1;  logic [5:0] g1;
    logic [239:0] c40; logic v40, l40, d40; logic [5:0] g40;

    skinny_constants_inv #(.RNDS_PER_CLK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .next(next),
        .constant(c4), .valid(v4), .last(l4), .done(d4), .grp(g4));
    skinny_constants_inv #(.RNDS_PER_CLK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .next(next),
        .constant(c1), .valid(v1), .last(l1), .done(d1), .grp(g1));
    skinny_constants_inv #(.RNDS_PER_CLK(40)) dut40 (
        .clk(clk), .rst_n(rst_n), .start(start), .next(next),
        .constant(c40), .valid(v40), .last(l40), .done(d40), .grp(g40));

    int checks = 0;
    int errors = 0;

    // rc_tab[r] is the constant used in encryption round r.
    logic [5:0] rc_tab [40];
    int  rs [3] = '{4, 1, 40};
    bit  m_valid [3];
    bit  m_done  [3];
    int  m_grp   [3];
    logic [5:0] stream [$];

    function automatic logic [5:0] f_fwd(input logic [5:0] x);
        return {x[4:0], x[5] ^ x[4] ^ 1'b1};
    endfunction

    function automatic logic [239:0] exp_const(input int j);
        logic [239:0] r = '0;
        if (m_valid[j])
            for (int i = 0; i < rs[j]; i++)
                r[6*i +: 6] = rc_tab[39 - m_grp[j]*rs[j] - i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [239:0] obs, input logic [239:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            m_valid[j] = 1'b0; m_done[j] = 1'b0; m_grp[j] = 0;
        end
    endtask

    task automatic model_step();
        for (int j = 0; j < 3; j++) begin
            int ng = 40 / rs[j];
            m_done[j] = 1'b0;
            if (!rst_n) begin
                m_valid[j] = 1'b0; m_grp[j] = 0;
            end else if (start) begin
                m_valid[j] = 1'b1; m_grp[j] = 0;
            end else if (m_valid[j] && next) begin
                if (m_grp[j] == ng - 1) begin
                    m_valid[j] = 1'b0; m_grp[j] = 0; m_done[j] = 1'b1;
                end else begin
                    m_grp[j] = m_grp[j] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 3; j++) begin
            logic [239:0] oc; logic ov, ol, od; logic [5:0] og;
            bit exp_last;
            case (j)
                0:       begin oc = 240'(c4);  ov = v4;  ol = l4;  od = d4;  og = g4;  end
                1:       begin oc = 240'(c1);  ov = v1;  ol = l1;  od = d1;  og = g1;  end
                default: begin oc = c40;       ov = v40; ol = l40; od = d40; og = g40; end
            endcase
            exp_last = m_valid[j] && (m_grp[j] == 40 / rs[j] - 1);
            chk($sformatf("r%0d.constant", rs[j]), oc, exp_const(j));
            chk($sformatf("r%0d.valid", rs[j]), 240'(ov), 240'(m_valid[j]));
            chk($sformatf("r%0d.last", rs[j]), 240'(ol), 240'(exp_last));
            chk($sformatf("r%0d.done", rs[j]), 240'(od), 240'(m_done[j]));
            chk($sformatf("r%0d.grp", rs[j]), 240'(og), 240'(m_grp[j]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        $display("t=%0t rst_n=%b start=%b next=%b | r4 grp=%0d c=%h v=%b l=%b d=%b | r1 c=%h | r40 v=%b d=%b",
                 $time, rst_n, start, next, g4, c4, v4, l4, d4, c1, v40, d40);
    endtask

    localparam logic [23:0] GRP0 = {6'h1B, 6'h36, 6'h2D, 6'h1A};
    localparam logic [23:0] GRP1 = {6'h31, 6'h23, 6'h06, 6'h0D};
    localparam logic [23:0] GRP9 = {6'h01, 6'h03, 6'h07, 6'h0F};

    initial begin
        bit did5 = 1'b0, did3 = 1'b0, reached6 = 1'b0;
        logic [23:0] prev_c4;

        rc_tab[0] = f_fwd(6'h00);
        for (int r = 1; r < 40; r++) rc_tab[r] = f_fwd(rc_tab[r-1]);

        // Reset state
        rst_n = 1'b0; start = 1'b0; next = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single start pulse, then idle
        start = 1'b1; tick();
        start = 1'b0;
        chk("grp0.literal", 240'(c4), 240'(GRP0));
        chk("r40.lane0", 240'(c40[5:0]), 240'(6'h1A));
        chk("r40.lane39", 240'(c40[239:234]), 240'(6'h01));
        repeat (2) tick();

        // Full sweep with next held high from start
        start = 1'b1; next = 1'b1; tick();
        start = 1'b0;
        if (v1) stream.push_back(c1);
        for (int k = 0; k < 42; k++) begin
            tick();
            if (v1) stream.push_back(c1);
            if (m_valid[0] && m_grp[0] == 1) chk("grp1.literal", 240'(c4), 240'(GRP1));
            if (m_valid[0] && m_grp[0] == 9) chk("grp9.literal", 240'(c4), 240'(GRP9));
        end
        chk("r1.stream_len", 240'(stream.size()), 240'(40));
        if (stream.size() == 40) begin
            chk("r1.stream_first", 240'(stream[0]), 240'(6'h1A));
            chk("r1.stream_end", 240'(stream[39]), 240'(6'h01));
            for (int k = 39; k > 0; k--)
                chk($sformatf("r1.fwd%0d", k), 240'(f_fwd(stream[k])), 240'(stream[k-1]));
        end
        next = 1'b0;
        tick();

        // Random next gaps, restart at grp 5, start+next at grp 3
        start = 1'b1; tick();
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!did5 && m_valid[0] && m_grp[0] == 5) begin
                start = 1'b1; next = 1'($urandom_range(0, 1)); did5 = 1'b1;
            end else if (did5 && !did3 && m_valid[0] && m_grp[0] == 3) begin
                start = 1'b1; next = 1'b1; did3 = 1'b1;
            end else begin
                start = 1'b0; next = ($urandom_range(0, 2) == 0);
            end
            prev_c4 = c4;
            tick();
            if (!start && !next && m_valid[0]) chk("r4.hold", 240'(c4), 240'(prev_c4));
            if (did3 && !m_valid[0]) break;
        end
        chk("restart_at_5_seen", 240'(did5), 240'(1));
        chk("restart_at_3_seen", 240'(did3), 240'(1));
        start = 1'b0; next = 1'b0;
        tick();

        // Asynchronous reset mid-run at grp 6
        start = 1'b1; tick();
        start = 1'b0; next = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_grp[0] == 6) begin reached6 = 1'b1; break; end
        end
        chk("reached_grp6", 240'(reached6), 240'(1));
        next = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        tick();
        #2 rst_n = 1'b1;
        next = 1'b1;
        tick();
        next = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_reset_grp0", 240'(c4), 240'(GRP0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skinny_constants_inv.md
Name: skinny_constants_inv

Overview:
- Sequential round-constant generator for SKINNY-128-384 decryption.
- Emits the 6-bit round constants in reverse round order, 39 down to 0, with RNDS_PER_CLK constants per clock.
- The constants come from the inverted 6-bit LFSR rather than a lookup table.
- Feeds the inverse round datapath.
- Its output packing matches the encryption constant bus: lane i occupies bits [6i+5:6i].

Parameters:
- RNDS_PER_CLK, 4: constants per group/clock. Must divide TOTAL_RNDS. Legal values 1, 2, 4, 5, 8, 10, 20, 40.
- TOTAL_RNDS, 40: number of cipher rounds.
- RC_LAST, 6'h1A: constant of round TOTAL_RNDS-1, loaded on start.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- start  input  1  load RC_LAST and begin a decryption sequence
- next  input  1  consume current group, advance to following group
- constant  output  6*RNDS_PER_CLK  current group; lane i = constant of round (R_top - i)
- valid  output  1  constant holds a live group
- last  output  1  current group contains round 0
- done  output  1  one-cycle pulse after the final group is consumed
- grp  output  6  current group index, counting 0 .. TOTAL_RNDS/RNDS_PER_CLK-1

Behaviour:
- Forward LFSR (reference only): f(rc) = {rc[4:0], rc[5]^rc[4]^1}.
- Inverse: g(n) = {n[0]^n[5]^1, n[5:1]}. It satisfies g(f(x)) = x for all 6-bit x.
- State registers:
  - rc[5:0]: lane-0 constant.
  - grp counter.
  - valid flag.
  - done flag.
- Combinational chain: lane0 = rc, lane(i) = g(lane(i-1)) for i = 1 .. RNDS_PER_CLK-1.
- constant is driven from the chain whenever valid=1. It is forced to all zeros when valid=0.
- Reset (async, rst_n=0):
  - rc = RC_LAST, grp = 0.
  - valid = 0, done = 0, last = 0, constant = 0.
- States (implicit in valid): IDLE (valid=0) and RUN (valid=1).
- IDLE, start=1:
  - Next cycle: rc = RC_LAST, grp = 0, valid = 1.
  - Latency from start to valid is 1 clock.
- RUN, next=1, last=0: next cycle rc = g^RNDS_PER_CLK(rc), i.e. g applied to the last lane, and grp = grp+1.
- RUN, next=1, last=1:
  - Next cycle: valid = 0, done = 1 for exactly one cycle.
  - rc = RC_LAST and grp = 0 are restored.
- last is combinational: last = valid & (grp == TOTAL_RNDS/RNDS_PER_CLK - 1).
- next while valid=0 is ignored, with no state change.
- Holding next low in RUN holds constant and grp stable indefinitely.
- start in RUN restarts: rc = RC_LAST, grp = 0, valid stays 1, no done pulse.
- start and next in the same cycle: start wins and next is discarded.
- done is a registered pulse. It clears the following cycle unless the sequence completes again, which is impossible within one cycle.
- rst_n asserted mid-sequence: immediate return to reset values. There is no partial output and no done pulse.
- grp arithmetic:
  - Unsigned 6-bit.
  - Never exceeds TOTAL_RNDS/RNDS_PER_CLK-1.
  - No wrap beyond the end; the sequence terminates at that value.
- At elaboration, an illegal RNDS_PER_CLK (TOTAL_RNDS % RNDS_PER_CLK != 0) is flagged with $error.

Test Plan:
- RNDS_PER_CLK=4: reset, pulse start → next cycle valid=1, grp=0, lanes 0..3 = 1A, 2D, 36, 1B, last=0.
- RNDS_PER_CLK=4, next held high from start → 10 groups on consecutive cycles.
  - Group 1 lanes = 0D, 06, 23, 31.
  - Group 9 lanes = 0F, 07, 03, 01 with last=1.
  - Following cycle: valid=0, done=1, constant=0.
  - One cycle later: done=0.
- RNDS_PER_CLK=1 full sweep → 40 single constants: 1A, 2D, 36, 1B, 0D, ... , 07, 03, 01.
  - Applying f in hardware-model order to the reversed stream reproduces 01, 03, 07, 0F, 1F, 3E, ...
- RNDS_PER_CLK=40 → one group: lane 0 = 1A, lane 39 = 01, last=1 immediately. next → done pulse.
- RNDS_PER_CLK=4, random next gaps:
  - Output is stable while next=0.
  - start at grp=5 → group 0 (1A, 2D, 36, 1B) next cycle, no done.
  - start+next together at grp=3 → restart to grp=0.
- Assert rst_n low at grp=6 mid-run → valid, done, constant go 0 asynchronously. After release, next alone has no effect. start → lanes 1A, 2D, 36, 1B.
